// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
//   Read-side controller for a synchronous FIFO with 1-cycle read latency.
//   A start command pops exactly len words. Popped words land in a 2-entry
//   skid buffer and are presented on a valid/ready stream at up to one word
//   per cycle. done pulses for one cycle after the last word is accepted.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   start, len            burst command (sampled only in IDLE)
//   busy, done            burst in progress / 1-cycle completion pulse
//   fifo_empty            FIFO empty flag
//   fifo_rd_data          FIFO read data, valid the cycle after fifo_r_e
//   fifo_r_e              FIFO pop strobe (combinational)
//   m_valid, m_data       stream output (skid head)
//   m_ready               stream back-pressure
//   words_out             words accepted downstream in the current/last burst
//   dbg_state             current FSM state, for observation only
//
// Stream handshake: a word transfers on every rising edge where
// m_valid && m_ready. Once m_valid is high it stays high, with m_data
// unchanged, until that transfer happens (only reset can drop it early).

module fifo_burst_reader #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              fifo_r_e,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic [LEN_W-1:0]  words_out,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issued;
    logic              inflight;
    logic [DATA_W-1:0] skid0;
    logic [DATA_W-1:0] skid1;
    logic [1:0]        skid_cnt;

    logic pop_now;
    logic last_pop;
    logic occ_ok;
    logic accept_start;
    logic zero_start;

    assign m_valid   = (skid_cnt != 2'd0);
    assign m_data    = skid0;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    assign pop_now  = m_valid && m_ready;
    assign last_pop = pop_now && (state != IDLE) && ((words_out + LEN_W'(1)) == len_q);

    // A new read may be issued only if every word already owed to the skid
    // (buffered + in flight) plus this one still fits in 2 entries, counting
    // the slot freed by a same-cycle pop. Written as a <= b + pop to avoid
    // unsigned underflow.
    assign occ_ok = ({1'b0, skid_cnt} + {2'b00, inflight} + 3'd1) <= (3'd2 + {2'b00, pop_now});

    always_comb begin
        state_nxt    = state;
        fifo_r_e     = 1'b0;
        accept_start = 1'b0;
        zero_start   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        accept_start = 1'b1;
                        state_nxt    = BURST;
                    end else begin
                        zero_start = 1'b1;
                    end
                end
            end
            BURST: begin
                fifo_r_e = !fifo_empty && (issued < len_q) && occ_ok;
                // The final word can be accepted in the same cycle the last
                // read is seen as issued, so completion must be checked here too.
                if (last_pop) begin
                    state_nxt = IDLE;
                end else if (issued == len_q) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (last_pop) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            len_q     <= '0;
            issued    <= '0;
            words_out <= '0;
            inflight  <= 1'b0;
            skid0     <= '0;
            skid1     <= '0;
            skid_cnt  <= 2'd0;
            done      <= 1'b0;
        end else begin
            state    <= state_nxt;
            done     <= last_pop || zero_start;
            inflight <= fifo_r_e;

            if (accept_start) begin
                len_q     <= len;
                issued    <= '0;
                words_out <= '0;
            end else begin
                if (fifo_r_e) begin
                    issued <= issued + LEN_W'(1);
                end
                if (pop_now) begin
                    words_out <= words_out + LEN_W'(1);
                end
            end

            // Skid buffer: entry 0 is the head. The word returning from the
            // FIFO (inflight) is appended at the tail; a pop shifts entry 1 down.
            case ({inflight, pop_now})
                2'b10: begin
                    if (skid_cnt == 2'd0) begin
                        skid0 <= fifo_rd_data;
                    end else begin
                        skid1 <= fifo_rd_data;
                    end
                    skid_cnt <= skid_cnt + 2'd1;
                end
                2'b01: begin
                    skid0    <= skid1;
                    skid_cnt <= skid_cnt - 2'd1;
                end
                2'b11: begin
                    if (skid_cnt == 2'd2) begin
                        skid0 <= skid1;
                        skid1 <= fifo_rd_data;
                    end else begin
                        skid0 <= fifo_rd_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a queue-based FIFO model feeds the DUT, every
// pushed word goes to an expected queue, and a count-based model of the
// burst protocol predicts busy/done/words_out each cycle.

module tb_fifo_burst_reader;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 8;

    logic              clk;
    logic              reset;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              done;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_r_e;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;
    logic [LEN_W-1:0]  words_out;
    logic [1:0]        dbg_state;

    fifo_burst_reader #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .busy(busy), .done(done), .fifo_empty(fifo_empty),
        .fifo_rd_data(fifo_rd_data), .fifo_r_e(fifo_r_e),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .words_out(words_out), .dbg_state(dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_bad = 0;

    logic [DATA_W-1:0] fifo_q[$];
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] feed_q[$];

    int   ready_mode = 0;   // 0 always ready, 1 toggle, 2 random, 3 held low
    logic tog = 1'b0;

    // model state
    logic mdl_busy = 1'b0;
    logic mdl_done = 1'b0;
    int   mdl_words = 0;
    int   mdl_len = 0;
    int   pend = 0;
    int   rd_cnt = 0;
    int   first_hs = -1;
    int   last_hs = -1;
    int   t_start = 0;
    logic done_seen = 1'b0;
    logic hold_v = 1'b0;
    logic [DATA_W-1:0] hold_d = '0;
    logic hs;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [DATA_W-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        fifo_empty <= 1'b0;
    endtask

    // ---------------- FIFO model (1-cycle read latency) ----------------
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_rd_data <= '0;
        end else begin
            if (fifo_r_e && fifo_q.size() > 0) fifo_rd_data <= fifo_q.pop_front();
            fifo_empty <= (fifo_q.size() == 0);
        end
    end

    // ---------------- background drivers ----------------
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: m_ready = 1'b1;
            1: begin tog = ~tog; m_ready = tog; end
            2: m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
        endcase
        if (reset && feed_q.size() > 0 && $urandom_range(0, 2) == 0) push_word(feed_q.pop_front());
    end

    // ---------------- monitor, scoreboard and protocol model ----------------
    always @(negedge clk) begin
        if (reset) begin
            hs = m_valid && m_ready;
            check("busy", busy, mdl_busy);
            check("done", done, mdl_done);
            check("words_out", 64'(words_out), 64'(mdl_words));
            if (!mdl_busy) check("idle_valid_rd", {m_valid, fifo_r_e}, 2'b00);
            if (hold_v) begin
                check("stall_valid", m_valid, 1'b1);
                check("stall_data", m_data, hold_d);
            end
            if (fifo_r_e) begin
                check("rd_on_empty", fifo_empty, 1'b0);
                check("outstanding_le2", (pend + 1 - int'(hs)) <= 2, 1'b1);
                check("reads_le_len", (rd_cnt + 1) <= mdl_len, 1'b1);
            end
            if (hs) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_word: got %0h expected no word (t=%0t)", m_data, $time);
                end else begin
                    check("m_data", m_data, exp_q.pop_front());
                end
            end

            pend = pend + int'(fifo_r_e) - int'(hs);
            if (fifo_r_e) rd_cnt++;
            if (hs) begin
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
            end
            hold_v = m_valid && !m_ready;
            hold_d = m_data;
            if (done) done_seen = 1'b1;

            mdl_done = 1'b0;
            if (!mdl_busy) begin
                if (start) begin
                    if (len == '0) begin
                        mdl_done = 1'b1;
                    end else begin
                        mdl_busy  = 1'b1;
                        mdl_len   = int'(len);
                        mdl_words = 0;
                        rd_cnt    = 0;
                        first_hs  = -1;
                        last_hs   = -1;
                        t_start   = cyc + 1;
                        done_seen = 1'b0;
                    end
                end
            end else if (hs) begin
                mdl_words++;
                if (mdl_words == mdl_len) begin
                    mdl_busy = 1'b0;
                    mdl_done = 1'b1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        #1;
        check("rst_fifo_r_e", fifo_r_e, 1'b0);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data", m_data, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_words_out", 64'(words_out), 64'h0);
        fifo_q.delete();
        exp_q.delete();
        feed_q.delete();
        fifo_empty <= 1'b1;
        mdl_busy = 1'b0; mdl_done = 1'b0; mdl_words = 0; mdl_len = 0;
        pend = 0; rd_cnt = 0; hold_v = 1'b0; done_seen = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic do_start(input int l);
        @(posedge clk);
        #1;
        start = 1'b1;
        len   = LEN_W'(l);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int i;
        i = 0;
        while (!done_seen && i < budget) begin
            @(posedge clk);
            i++;
        end
        check(name, done_seen, 1'b1);
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int pre;
        int blen;
        int rmode;
        int base;
        int exp_words;
        int exp_reads;
        int first_lat;
        bit no_bubble;
    } vec_t;

    vec_t vt[6];

    initial begin
        int rl;
        int rpre;
        int i;

        vt[0] = '{8, 8, 0,   10, 8, 8,  2, 1'b1};  // 10..80 back to back
        vt[1] = '{8, 8, 1, 1000, 8, 8, -1, 1'b0};  // toggling ready
        vt[2] = '{5, 5, 2, 2000, 5, 5, -1, 1'b0};  // random ready
        vt[3] = '{1, 1, 0, 3000, 1, 1,  2, 1'b1};  // single word
        vt[4] = '{6, 3, 0, 4000, 3, 3,  2, 1'b1};  // leaves 3 words behind
        vt[5] = '{0, 3, 0,    0, 3, 3,  2, 1'b1};  // consumes the leftovers

        reset = 1'b0;
        start = 1'b0;
        len = '0;
        m_ready = 1'b1;
        fifo_empty <= 1'b1;
        apply_reset();

        for (int k = 0; k < 6; k++) begin
            ready_mode = vt[k].rmode;
            for (int j = 0; j < vt[k].pre; j++) push_word(DATA_W'(vt[k].base + 10 * j));
            do_start(vt[k].blen);
            wait_done(200, "tbl_done");
            check("tbl_words_out", 64'(words_out), 64'(vt[k].exp_words));
            check("tbl_reads", 64'(rd_cnt), 64'(vt[k].exp_reads));
            if (vt[k].first_lat >= 0) check("tbl_latency", 64'(first_hs - t_start), 64'(vt[k].first_lat));
            if (vt[k].no_bubble) check("tbl_no_bubble", 64'(last_hs - first_hs), 64'(vt[k].exp_words - 1));
        end

        // FIFO runs dry mid-burst, then refills
        ready_mode = 0;
        for (int j = 0; j < 3; j++) push_word(DATA_W'(100 + j));
        do_start(5);
        repeat (12) @(posedge clk);
        #1;
        check("dry_busy_held", busy, 1'b1);
        check("dry_words_out", 64'(words_out), 64'd3);
        push_word(32'd103);
        push_word(32'd104);
        wait_done(100, "dry_done");
        check("dry_words_final", 64'(words_out), 64'd5);
        check("dry_reads", 64'(rd_cnt), 64'd5);

        // toggling ready, then a 4-cycle stall
        ready_mode = 1;
        for (int j = 0; j < 8; j++) push_word(DATA_W'(200 + j));
        do_start(8);
        repeat (4) @(posedge clk);
        ready_mode = 3;
        repeat (4) @(posedge clk);
        ready_mode = 1;
        wait_done(200, "stall_done");
        check("stall_words_out", 64'(words_out), 64'd8);
        check("stall_exp_empty", 64'(exp_q.size()), 64'd0);

        // zero-length command
        ready_mode = 0;
        push_word(32'd9000);
        push_word(32'd9001);
        do_start(0);
        check("zero_done", done, 1'b1);
        check("zero_busy", busy, 1'b0);
        check("zero_rd", fifo_r_e, 1'b0);
        @(posedge clk);
        #1;
        check("zero_done_pulse", done, 1'b0);
        check("zero_busy2", busy, 1'b0);
        check("zero_rd2", fifo_r_e, 1'b0);
        do_start(2);
        wait_done(100, "zero_flush_done");

        // start while busy is ignored
        ready_mode = 1;
        for (int j = 0; j < 8; j++) push_word(DATA_W'(5000 + j));
        do_start(8);
        repeat (3) @(posedge clk);
        do_start(3);
        wait_done(200, "ign_done");
        check("ign_words_out", 64'(words_out), 64'd8);
        check("ign_reads", 64'(rd_cnt), 64'd8);
        check("ign_exp_empty", 64'(exp_q.size()), 64'd0);

        // reset after 3 of 8 words
        ready_mode = 0;
        for (int j = 0; j < 8; j++) push_word(DATA_W'(6000 + j));
        do_start(8);
        i = 0;
        while (mdl_words < 3 && i < 50) begin
            @(posedge clk);
            i++;
        end
        check("mid_reached3", mdl_words >= 3, 1'b1);
        apply_reset();
        push_word(32'd7000);
        push_word(32'd7001);
        do_start(2);
        wait_done(100, "post_rst_done");
        check("post_rst_words", 64'(words_out), 64'd2);
        check("post_rst_reads", 64'(rd_cnt), 64'd2);

        // randomized bursts against the reference model
        for (int r = 0; r < 20; r++) begin
            rl = $urandom_range(1, 12);
            rpre = $urandom_range(0, rl);
            ready_mode = $urandom_range(0, 2);
            for (int j = 0; j < rpre; j++) push_word($urandom);
            for (int j = rpre; j < rl; j++) feed_q.push_back($urandom);
            do_start(rl);
            wait_done(600, "rnd_done");
            check("rnd_words_out", 64'(words_out), 64'(rl));
            check("rnd_reads", 64'(rd_cnt), 64'(rl));
        end

        check("final_exp_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
